alu_issue_unit: RTL

Byte-serial front end that drives the 16-bit ALU from the CPU's 8-bit internal data path. It latches an operation code, collects four operand bytes (A low, A high, B low, B high) over a valid/ready handshake, and presents them to the ALU as stable registered signals. It captures the ALU's result and flags, then returns the two result bytes over a second valid/ready handshake. It sits between the control unit / register file byte bus and the combinational ALU.

---
 rtl/alu_issue_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_unit.sv
// Byte-serial issue front end for the 16-bit ALU: collects op code and four operand bytes,
// holds them stable for the ALU, captures result/flags and returns two result bytes.
// Optional build macro: ECPU_ALU_ISSUE_ZERO_CALC_EN (zero flag computed locally from the result).
module alu_issue_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] op_in,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic [7:0] alu_op,
    output logic [7:0] alu_a_low,
    output logic [7:0] alu_a_high,
    output logic [7:0] alu_b_low,
    output logic [7:0] alu_b_high,
    input  logic [7:0] alu_res_low,
    input  logic [7:0] alu_res_high,
    input  logic       alu_zerof,
    input  logic       alu_overf,
    output logic       zero_flag,
    output logic       over_flag
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_AL = 3'd1,
        LOAD_AH = 3'd2,
        LOAD_BL = 3'd3,
        LOAD_BH = 3'd4,
        EXEC    = 3'd5,
        OUT_L   = 3'd6,
        OUT_H   = 3'd7
    } state_t;

    state_t      state_r;
    logic [7:0]  alu_op_r;
    logic [7:0]  a_low_r;
    logic [7:0]  a_high_r;
    logic [7:0]  b_low_r;
    logic [7:0]  b_high_r;
    logic [15:0] result_r;
    logic [7:0]  out_data_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;
    logic        zero_flag_r;
    logic        over_flag_r;
    logic        in_xfer_s;
    logic        out_xfer_s;
    logic        zero_next_s;

`ifdef ECPU_ALU_ISSUE_ZERO_CALC_EN
    function automatic logic is_zero16(input logic [15:0] value);
        return (value == 16'h0000);
    endfunction
`endif

    // Handshake qualifiers and the zero flag source for the EXEC capture.
    always_comb begin
        in_xfer_s  = in_valid && in_ready_r;
        out_xfer_s = out_valid_r && out_ready;
`ifdef ECPU_ALU_ISSUE_ZERO_CALC_EN
        zero_next_s = is_zero16({alu_res_high, alu_res_low});
`else
        zero_next_s = alu_zerof;
`endif
    end

    // Sequencer: state, operand registers, result capture and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            alu_op_r    <= 8'h00;
            a_low_r     <= 8'h00;
            a_high_r    <= 8'h00;
            b_low_r     <= 8'h00;
            b_high_r    <= 8'h00;
            result_r    <= 16'h0000;
            out_data_r  <= 8'h00;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            zero_flag_r <= 1'b0;
            over_flag_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        alu_op_r   <= op_in;
                        state_r    <= LOAD_AL;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD_AL: begin
                    if (in_xfer_s) begin
                        a_low_r <= in_data;
                        state_r <= LOAD_AH;
                    end else begin
                        state_r <= LOAD_AL;
                    end
                end
                LOAD_AH: begin
                    if (in_xfer_s) begin
                        a_high_r <= in_data;
                        state_r  <= LOAD_BL;
                    end else begin
                        state_r <= LOAD_AH;
                    end
                end
                LOAD_BL: begin
                    if (in_xfer_s) begin
                        b_low_r <= in_data;
                        state_r <= LOAD_BH;
                    end else begin
                        state_r <= LOAD_BL;
                    end
                end
                LOAD_BH: begin
                    // Dropping in_ready here keeps it from ever overlapping out_valid.
                    if (in_xfer_s) begin
                        b_high_r   <= in_data;
                        state_r    <= EXEC;
                        in_ready_r <= 1'b0;
                    end else begin
                        state_r <= LOAD_BH;
                    end
                end
                EXEC: begin
                    result_r    <= {alu_res_high, alu_res_low};
                    zero_flag_r <= zero_next_s;
                    over_flag_r <= alu_overf;
                    out_data_r  <= alu_res_low;
                    out_valid_r <= 1'b1;
                    state_r     <= OUT_L;
                end
                OUT_L: begin
                    if (out_xfer_s) begin
                        out_data_r <= result_r[15:8];
                        state_r    <= OUT_H;
                    end else begin
                        out_data_r <= result_r[7:0];
                        state_r    <= OUT_L;
                    end
                end
                OUT_H: begin
                    if (out_xfer_s) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= OUT_H;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign alu_op     = alu_op_r;
    assign alu_a_low  = a_low_r;
    assign alu_a_high = a_high_r;
    assign alu_b_low  = b_low_r;
    assign alu_b_high = b_high_r;
    assign out_data   = out_data_r;
    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign zero_flag  = zero_flag_r;
    assign over_flag  = over_flag_r;

endmodule
